enc_bundler: RTL

Accumulating bundler that sits directly downstream of the encoder binder packs. Over `BEATS` consecutive beats it takes `LANES` shifted (bound) hypervectors per beat and keeps a per-bit-position count of set bits. After the last beat it thresholds the counts into one query hypervector, which it holds behind a valid/ready handshake until the classifier stage accepts it.

---
 rtl/enc_bundler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/enc_bundler.sv
// Purpose : bundles LANES*BEATS bound hypervectors into one thresholded query hypervector.
// Latency : query_hv/query_valid are registered 1 cycle after the edge that accepts the last beat.
// Backpressure: the result is held with query_valid high until query_ready; beats are not back-pressured.
//
// Build option: define ENC_BUNDLER_THIN_EN to enable segment thinning (at most one set bit per SEG_LEN).
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   start_encoding            pulse: clear counters and arm a new sample (wins over everything else)
//   in_valid, shifted_hv      one binder pack (LANES bound HVs) per valid beat
//   busy, beat_idx            high in ACCUM/THRESH; index of the next beat expected
//   query_valid, query_ready  result handshake
//   query_hv                  bundled query hypervector

package enc_bundler_pkg;
    localparam int HV_DIM = 256;
endpackage

module enc_bundler #(
    parameter int HV_DIM    = enc_bundler_pkg::HV_DIM,
    parameter int LANES     = 10,
    parameter int BEATS     = 28,
    parameter int CNT_W     = $clog2(LANES*BEATS+1),
    parameter int THRESHOLD = 1,
    parameter int SEG_LEN   = 64
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start_encoding,
    input  logic                       in_valid,
    input  logic [HV_DIM-1:0]          shifted_hv [0:LANES-1],
    output logic                       busy,
    output logic [$clog2(BEATS)-1:0]   beat_idx,
    output logic                       query_valid,
    input  logic                       query_ready,
    output logic [HV_DIM-1:0]          query_hv
);

    localparam int SUM_W = $clog2(LANES+1);
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS-1);

    // Thinning slices the vector into whole segments.
    if ((HV_DIM % SEG_LEN) != 0) begin : g_seg_check
        $error("HV_DIM must be a multiple of SEG_LEN");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_THRESH,
        S_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt      [HV_DIM];
    logic [SUM_W-1:0]   lane_sum [HV_DIM];
    logic [HV_DIM-1:0]  next_q;

    // Per-position population count across the lanes of one beat.
    always_comb begin : lane_add
        for (int b = 0; b < HV_DIM; b++) begin
            lane_sum[b] = '0;
            for (int l = 0; l < LANES; l++) begin
                lane_sum[b] = lane_sum[b] + SUM_W'(shifted_hv[l][b]);
            end
        end
    end

`ifdef ENC_BUNDLER_THIN_EN
    localparam int NUM_SEG = HV_DIM / SEG_LEN;

    // Keep only the strongest position per segment; strict '>' makes the
    // lowest index win a tie.
    always_comb begin : thr_logic
        logic [CNT_W-1:0] best_val;
        int               best_pos;
        best_val = '0;
        best_pos = 0;
        next_q   = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            best_val = cnt[s*SEG_LEN];
            best_pos = s*SEG_LEN;
            for (int i = 1; i < SEG_LEN; i++) begin
                if (cnt[s*SEG_LEN+i] > best_val) begin
                    best_val = cnt[s*SEG_LEN+i];
                    best_pos = s*SEG_LEN + i;
                end
            end
            if (int'(best_val) >= THRESHOLD) begin
                next_q[best_pos] = 1'b1;
            end
        end
    end
`else
    always_comb begin : thr_logic
        next_q = '0;
        for (int b = 0; b < HV_DIM; b++) begin
            next_q[b] = (int'(cnt[b]) >= THRESHOLD);
        end
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            beat_idx    <= '0;
            query_valid <= 1'b0;
            query_hv    <= '0;
            for (int b = 0; b < HV_DIM; b++) begin
                cnt[b] <= '0;
            end
        end else if (start_encoding) begin
            // Restart discards any partial sample or unaccepted result,
            // including a beat presented in the same cycle.
            state       <= S_ACCUM;
            busy        <= 1'b1;
            beat_idx    <= '0;
            query_valid <= 1'b0;
            for (int b = 0; b < HV_DIM; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            case (state)
                S_ACCUM: begin
                    if (in_valid) begin
                        for (int b = 0; b < HV_DIM; b++) begin
                            cnt[b] <= cnt[b] + CNT_W'(lane_sum[b]);
                        end
                        beat_idx <= beat_idx + BW'(1);
                        if (beat_idx == LAST_BEAT) begin
                            state <= S_THRESH;
                        end
                    end
                end
                S_THRESH: begin
                    query_hv    <= next_q;
                    query_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (query_ready) begin
                        query_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
